// File: rtl/tlp_req_splitter.sv
// tlp_req_splitter: cuts one DMA request into RCB/max-payload aligned TLP descriptors
module tlp_req_splitter #(
  parameter int AW       = 64,
  parameter int BCW      = 32,
  parameter int WITH_RCB = 1,
  parameter int RCB_LOG2 = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [BCW-1:0] req_bcnt,
  input  logic [2:0]    ms_pld,
  output logic          tlp_valid,
  input  logic          tlp_ready,
  output logic [AW-1:0] tlp_addr,
  output logic [12:0]   tlp_len,
  output logic          tlp_first,
  output logic          tlp_last,
  output logic          busy
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_d;
  logic [BCW-1:0] rem, sel_rem;
  logic [AW-1:0] sel_addr;
  logic [2:0] mps, sel_mps, ms_clamp;
  logic [3:0] blog;
  logic [12:0] bsize, chunk, len;
  logic accept, hs, load;
  // One cut datapath serves both the accept and the handshake cycle, since they never coincide
  always_comb begin
    accept   = req_valid && req_ready;
    hs       = tlp_valid && tlp_ready;
    load     = (accept && req_bcnt != '0) || (hs && !tlp_last);
    ms_clamp = ms_pld > 3'd5 ? 3'd5 : ms_pld;
    sel_addr = accept ? req_addr : tlp_addr + AW'(tlp_len);
    sel_rem  = accept ? req_bcnt : rem - BCW'(tlp_len);
    sel_mps  = accept ? ms_clamp : mps;
    blog     = (WITH_RCB != 0 && sel_addr[RCB_LOG2-1:0] != '0) ? 4'(RCB_LOG2) : 4'd7 + {1'b0, sel_mps};
    bsize    = 13'd1 << blog;
    chunk    = bsize - (sel_addr[12:0] & (bsize - 13'd1));
    len      = BCW'(chunk) > sel_rem ? sel_rem[12:0] : chunk;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = load ? EMIT : (hs && tlp_last) ? IDLE : state;
  end
  always_comb begin
    req_ready = state == IDLE;
    busy      = state == EMIT;
    tlp_valid = state == EMIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tlp_addr  <= '0;
      rem       <= '0;
      mps       <= '0;
      tlp_len   <= '0;
      tlp_first <= 1'b0;
      tlp_last  <= 1'b0;
    end else if (load) begin
      tlp_addr  <= sel_addr;
      rem       <= sel_rem;
      mps       <= sel_mps;
      tlp_len   <= len;
      tlp_first <= accept;
      tlp_last  <= BCW'(len) == sel_rem;
    end
  end
endmodule

// File: doc/tlp_req_splitter.md
# tlp_req_splitter

Sequential successor to the combinational TLP cut logic. Accepts one DMA request (start address, byte count) at a time and emits a stream of TLP descriptors (address, length, first/last). Each descriptor is cut at the read-completion boundary (RCB) and at max-payload boundaries. Sits between the DMA descriptor engine and the TLP header builder, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `AW`, 64: address width.
- `BCW`, 32: request byte-count width.
- `WITH_RCB`, 1: when 1, a TLP starting off an RCB boundary is cut at the next RCB boundary; when 0, only max-payload cuts apply.
- `RCB_LOG2`, 6: RCB size is 2^RCB_LOG2 bytes (64 B).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle and able to accept a request.
- `req_addr`  in  AW  request start byte address.
- `req_bcnt`  in  BCW  request byte count.
- `ms_pld`  in  3  max payload encoding: 0=128 B, 1=256, 2=512, 3=1024, 4=2048, 5=4096; 6 and 7 are clamped to 5.
- `tlp_valid`  out  1  descriptor present.
- `tlp_ready`  in  1  downstream accepts descriptor.
- `tlp_addr`  out  AW  descriptor start address.
- `tlp_len`  out  13  descriptor length in bytes, 1..4096.
- `tlp_first`  out  1  first descriptor of the request.
- `tlp_last`  out  1  final descriptor of the request.
- `busy`  out  1  request in progress.

## Operation
- States:
  - `IDLE`: `req_ready`=1. On `req_valid` go to `EMIT`, or stay in `IDLE` if `req_bcnt`==0.
  - `EMIT`: descriptor held on outputs.
- Request accept (`req_valid && req_ready`):
  - latch `cur_addr`=`req_addr` and `rem`=`req_bcnt`.
  - latch the clamped `ms_pld` as `mps`. Later changes to `ms_pld` are ignored until the next accept.
- A request with `req_bcnt`==0 is accepted and discarded. No descriptor is produced and the block stays in `IDLE`.
- Cut size per descriptor:
  - boundary B = 2^RCB_LOG2 if `WITH_RCB` and `cur_addr[RCB_LOG2-1:0]`!=0; otherwise B = 2^(7+mps).
  - `chunk` = B − (`cur_addr` mod B).
  - `tlp_len` = min(`chunk`, `rem`).
- Because B ≤ 4096 and the cut is boundary-aligned, no descriptor crosses a 4 KB boundary.
- Flags:
  - `tlp_first`=1 only on the first descriptor after accept.
  - `tlp_last`=1 when `tlp_len`==`rem`.
- On descriptor handshake (`tlp_valid && tlp_ready`):
  - `cur_addr` += `tlp_len`, modulo 2^AW; address wrap is legal and silent.
  - `rem` −= `tlp_len`.
  - If `tlp_last`, go to `IDLE`; otherwise load the next descriptor.
- `busy` = (state==`EMIT`).
- Reset mid-operation abandons the request immediately. No partial or last descriptor is emitted.

## Timing
- All `tlp_*` outputs are registered. `req_ready` = (state==`IDLE`), decoded from the state register.
- Request accepted at edge N: `tlp_valid`=1 from cycle N+1 with the first descriptor.
- Back-to-back throughput: one descriptor per cycle while `tlp_ready`=1. The next descriptor is computed in the handshake cycle and appears on the following cycle.
- While `tlp_valid`=1 and `tlp_ready`=0, all `tlp_*` outputs hold stable.
- After the last handshake at edge M: `tlp_valid`=0 and `req_ready`=1 in cycle M+1. The next request can be accepted at edge M+1.
- Zero-byte request: accepted, and `req_ready` stays 1 in the next cycle.
- Reset values: `tlp_valid`=0, `tlp_addr`=0, `tlp_len`=0, `tlp_first`=0, `tlp_last`=0, `busy`=0, state=`IDLE`. `req_ready` is 1 from the first cycle after `rst` deasserts.
- Arithmetic widths:
  - `chunk` and `tlp_len` use 13 bits.
  - `rem` compare and subtract use BCW bits.
  - address add uses AW bits; carry out is discarded.

## Test plan
- Aligned request, `addr`=0x1000, `bcnt`=512, `ms_pld`=0 -> 4 descriptors of len 128 at 0x1000/0x1080/0x1100/0x1180. `first` is set only on #1 and `last` only on #4; one descriptor per cycle with `tlp_ready` tied high.
- RCB cut, `WITH_RCB`=1, `addr`=0x1010, `bcnt`=300, `ms_pld`=1 -> (0x1010, 48), (0x1040, 192), (0x1100, 60, last).
- Backpressure: same stimulus as scenario 1 with `tlp_ready` low for 3 cycles after descriptor #2 -> descriptor #2 held stable for all 3 cycles, no descriptor lost or duplicated, total still 4.
- Large payload and clamp:
  - `addr`=0x2000, `bcnt`=8192, `ms_pld`=5 -> 2 descriptors of len 4096.
  - Same request with `ms_pld`=7 -> identical result.
- Wrap and zero-length:
  - `addr`=0xFFFF_FFFF_FFFF_FFC0, `bcnt`=128, `ms_pld`=0 -> (…FFC0, 64), (0x0, 64, last).
  - `bcnt`=0 -> no `tlp_valid`, and `req_ready`=1 on the next cycle.
- Reset mid-stream: assert `rst` during descriptor #2 of scenario 1 -> next cycle `tlp_valid`=0, `busy`=0, all outputs 0. A fresh request then starts with `tlp_first`=1.
